// File: rtl/dsp_seq_pkg.sv
// Shared definitions for the DSP48A1 operand sequencer.
//   - OPMODE opcodes driven to the slice (X mux in [1:0], Z mux in [3:2])
//   - Sequencer state encoding
//   - drain_count(): cycles to wait after the last beat before P is final
package dsp_seq_pkg;

  // X=M, Z=0 : start a new dot product with the first product
  localparam logic [7:0] OP_MUL  = 8'h01;
  // X=M, Z=P : add the current product to the running sum
  localparam logic [7:0] OP_ACC  = 8'h09;
  // X=0, Z=P : keep P unchanged
  localparam logic [7:0] OP_HOLD = 8'h08;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  // The final product reaches P PIPE_LAT cycles after the operands are
  // driven, and its opmode trails the operands by MODE_DELAY more cycles.
  function automatic int drain_count(input int pipe_lat, input int mode_delay);
    return pipe_lat + mode_delay;
  endfunction

endpackage

// File: rtl/dsp_opmode_delay.sv
// Fixed-depth shift register for the 8-bit OPMODE word.
// Delays the opcode so it meets its matching product at the post-adder.
// DEPTH = 0 is a plain wire-through. All stages reset to OP_HOLD so the
// slice never sees a spurious multiply while the pipe refills.
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active-high
//   op_in   : opcode entering the delay line
//   op_out  : opcode delayed by DEPTH cycles
module dsp_opmode_delay
  import dsp_seq_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] op_in,
  output logic [7:0] op_out
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign op_out = op_in;
    end else begin : g_shift
      logic [7:0] stage_reg [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_reg[i] <= OP_HOLD;
          end
        end else begin
          stage_reg[0] <= op_in;
          for (int i = 1; i < DEPTH; i++) begin
            stage_reg[i] <= stage_reg[i-1];
          end
        end
      end

      assign op_out = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Operand sequencer feeding a Spartan-6 DSP48A1 slice so that the slice
// accumulates the dot product sum(a*b) of one vector in its P register.
// Beats arrive over valid/ready and are terminated by in_last. After the
// slice pipeline drains, P and CARRYOUT are captured and offered on a
// valid/ready result port together with the beat count.
// Ports:
//   CLK, RST              : clock (rising edge), async active-high reset
//   in_valid/in_ready     : operand beat handshake
//   in_a, in_b, in_last   : operands and end-of-vector marker
//   dsp_a, dsp_b          : to slice A / B
//   dsp_opmode            : to slice OPMODE (delayed by MODE_DELAY)
//   dsp_p, dsp_carryout   : from slice P / CARRYOUT
//   res_valid/res_ready   : result handshake
//   res_data, res_carry   : captured P and CARRYOUT
//   res_len               : beats in the vector (saturating)
//   len_err               : sticky beat-count overflow flag
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int OP_W       = 18,
  parameter int P_W        = 48,
  parameter int PIPE_LAT   = 3,
  parameter int MODE_DELAY = 1,
  parameter int CNT_W      = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_a,
  input  logic [OP_W-1:0]  in_b,
  input  logic             in_last,
  output logic [OP_W-1:0]  dsp_a,
  output logic [OP_W-1:0]  dsp_b,
  output logic [7:0]       dsp_opmode,
  input  logic [P_W-1:0]   dsp_p,
  input  logic             dsp_carryout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [P_W-1:0]   res_data,
  output logic             res_carry,
  output logic [CNT_W-1:0] res_len,
  output logic             len_err
);

  localparam int DRAIN_W = 8;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(drain_count(PIPE_LAT, MODE_DELAY));

  state_t             state_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [DRAIN_W-1:0] drain_reg;
  logic [7:0]         op_reg;
  logic               accept;

  assign accept = in_valid & in_ready;

  // in_ready is registered, so it is computed from the state being entered.
  // Operands and opcode default to zero / OP_HOLD every cycle, which makes
  // any cycle without an accepted beat a bubble that leaves P untouched.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      in_ready  <= 1'b0;
      dsp_a     <= '0;
      dsp_b     <= '0;
      op_reg    <= OP_HOLD;
      count_reg <= '0;
      drain_reg <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_len   <= '0;
      len_err   <= 1'b0;
    end else begin
      dsp_a  <= '0;
      dsp_b  <= '0;
      op_reg <= OP_HOLD;
      case (state_reg)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            dsp_a     <= in_a;
            dsp_b     <= in_b;
            op_reg    <= OP_MUL;  // discards whatever P held before
            count_reg <= CNT_W'(1);
            if (in_last) begin
              state_reg <= DRAIN;
              in_ready  <= 1'b0;
              drain_reg <= DRAIN_LOAD;
            end else begin
              state_reg <= ACCUM;
            end
          end
        end
        ACCUM: begin
          in_ready <= 1'b1;
          if (accept) begin
            dsp_a  <= in_a;
            dsp_b  <= in_b;
            op_reg <= OP_ACC;
            // Count saturates; the accumulation itself keeps going.
            if (count_reg == {CNT_W{1'b1}}) begin
              len_err <= 1'b1;
            end else begin
              count_reg <= count_reg + CNT_W'(1);
            end
            if (in_last) begin
              state_reg <= DRAIN;
              in_ready  <= 1'b0;
              drain_reg <= DRAIN_LOAD;
            end
          end
        end
        DRAIN: begin
          in_ready <= 1'b0;
          if (drain_reg == '0) begin
            res_data  <= dsp_p;
            res_carry <= dsp_carryout;
            res_len   <= count_reg;
            res_valid <= 1'b1;
            state_reg <= OUT;
          end else begin
            drain_reg <= drain_reg - DRAIN_W'(1);
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

  dsp_opmode_delay #(
    .DEPTH (MODE_DELAY)
  ) u_opmode_delay (
    .clk    (CLK),
    .rst    (RST),
    .op_in  (op_reg),
    .op_out (dsp_opmode)
  );

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer driving a behavioural DSP48A1 model
// (A1REG=B1REG=MREG=PREG=OPMODEREG=1, A0REG=B0REG=0).
module tb_dsp_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_a;
  logic [17:0] in_b;
  logic        in_last;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [7:0]  dsp_opmode;
  logic [47:0] dsp_p;
  logic        dsp_carryout;
  logic        res_valid;
  logic        res_ready;
  logic [47:0] res_data;
  logic        res_carry;
  logic [9:0]  res_len;
  logic        len_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int valid_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dsp_mac_sequencer dut (
    .CLK          (clk),
    .RST          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_last      (in_last),
    .dsp_a        (dsp_a),
    .dsp_b        (dsp_b),
    .dsp_opmode   (dsp_opmode),
    .dsp_p        (dsp_p),
    .dsp_carryout (dsp_carryout),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_carry    (res_carry),
    .res_len      (res_len),
    .len_err      (len_err)
  );

  // ---------------- DSP48A1 slice model (never reset by the sequencer) ----
  logic signed [17:0] a1 = 18'sd0;
  logic signed [17:0] b1 = 18'sd0;
  logic signed [35:0] m  = 36'sd0;
  logic [7:0]  opm = 8'h00;
  logic [47:0] p   = 48'h0123_4567_89AB;  // stale garbage in P at start
  logic        co  = 1'b0;
  logic [47:0] xmux;
  logic [47:0] zmux;

  assign xmux = (opm[1:0] == 2'b01) ? {{12{m[35]}}, m} : 48'h0;
  assign zmux = (opm[3:2] == 2'b10) ? p : 48'h0;

  always @(posedge clk) begin
    a1 <= dsp_a;
    b1 <= dsp_b;
    m  <= a1 * b1;
    opm <= dsp_opmode;
    {co, p} <= {1'b0, zmux} + {1'b0, xmux};
  end

  assign dsp_p        = p;
  assign dsp_carryout = co;

  // ---------------- opcode monitor ----------------
  logic       mon_en = 1'b0;
  logic [7:0] op_log[$];

  always @(negedge clk) begin
    if (mon_en && dsp_opmode != 8'h08) op_log.push_back(dsp_opmode);
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Present a beat from a negedge and return at the negedge after the
  // accepting edge, with in_valid still high so beats can run back-to-back.
  task automatic send(input logic [17:0] a, input logic [17:0] b, input logic last);
    int tmo;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    tmo = 0;
    while (in_ready !== 1'b1 && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 50) check("send_ready_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    accept_cyc = cyc;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  task automatic wait_result(input string tag, input logic [47:0] exp_data, input int exp_len);
    int tmo;
    tmo = 0;
    while (res_valid !== 1'b1 && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    valid_cyc = cyc;
    if (tmo >= 100) begin
      check({tag, "_timeout"}, 64'(res_valid), 64'd1);
    end else begin
      check({tag, "_data"}, 64'(res_data), 64'(exp_data));
      check({tag, "_len"}, 64'(res_len), 64'(exp_len));
      check({tag, "_carry"}, 64'(res_carry), 64'd0);
      $display("vector %s: data=0x%0h len=%0d", tag, res_data, res_len);
    end
  endtask

  task automatic take(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(res_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] op0, op1, op2;
    logic [47:0] held;

    rst = 1'b1;
    res_ready = 1'b0;
    idle_in();
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_dsp_a", 64'(dsp_a), 64'd0);
    check("rst_dsp_b", 64'(dsp_b), 64'd0);
    check("rst_opmode", 64'(dsp_opmode), 64'h08);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_res_len", 64'(res_len), 64'd0);
    check("rst_len_err", 64'(len_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single beat 15*2, latency 5 edges
    send(18'd15, 18'd2, 1'b1);
    idle_in();
    check("single_in_ready_low", 64'(in_ready), 64'd0);
    wait_result("single", 48'd30, 1);
    check("single_latency", 64'(valid_cyc - accept_cyc), 64'd5);
    take("single");

    // Three beats back-to-back: 12+30+56
    op_log.delete();
    mon_en = 1'b1;
    send(18'd3, 18'd4, 1'b0);
    send(18'd5, 18'd6, 1'b0);
    send(18'd7, 18'd8, 1'b1);
    idle_in();
    wait_result("three", 48'd98, 3);
    mon_en = 1'b0;
    op0 = (op_log.size() > 0) ? op_log[0] : 8'hFF;
    op1 = (op_log.size() > 1) ? op_log[1] : 8'hFF;
    op2 = (op_log.size() > 2) ? op_log[2] : 8'hFF;
    check("three_op_count", 64'(op_log.size()), 64'd3);
    check("three_op0", 64'(op0), 64'h01);
    check("three_op1", 64'(op1), 64'h09);
    check("three_op2", 64'(op2), 64'h09);
    take("three");

    // Bubbles: (2,3), 4-cycle gap, (4,5) last
    send(18'd2, 18'd3, 1'b0);
    idle_in();
    @(negedge clk);
    check("bubble0_a", 64'(dsp_a), 64'd0);
    check("bubble0_b", 64'(dsp_b), 64'd0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("bubble_a", 64'(dsp_a), 64'd0);
      check("bubble_b", 64'(dsp_b), 64'd0);
      check("bubble_op", 64'(dsp_opmode), 64'h08);
    end
    send(18'd4, 18'd5, 1'b1);
    idle_in();
    wait_result("bubble", 48'd26, 2);

    // Result backpressure for 10 cycles
    held = res_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_data", 64'(res_data), 64'(held));
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_valid", 64'(res_valid), 64'd1);
    end
    take("bp");
    send(18'd1, 18'd1, 1'b1);
    idle_in();
    wait_result("after_bp", 48'd1, 1);
    take("after_bp");

    // Signed: -63 + 100 = 37, then -25
    send(18'h3FFF9, 18'd9, 1'b0);   // -7
    send(18'd10, 18'd10, 1'b1);
    idle_in();
    wait_result("signed", 48'd37, 2);
    take("signed");
    send(18'h3FFFB, 18'd5, 1'b1);   // -5
    idle_in();
    wait_result("neg", 48'hFFFF_FFFF_FFE7, 1);
    take("neg");
    check("len_err_clear", 64'(len_err), 64'd0);

    // Beat count overflow: 1025 beats of 1*1
    for (int i = 0; i < 1025; i++) begin
      send(18'd1, 18'd1, (i == 1024) ? 1'b1 : 1'b0);
    end
    idle_in();
    wait_result("ovf", 48'd1025, 1023);
    check("ovf_len_err", 64'(len_err), 64'd1);
    take("ovf");
    check("ovf_len_err_sticky", 64'(len_err), 64'd1);

    // Reset during DRAIN
    send(18'd100, 18'd100, 1'b1);
    idle_in();
    rst = 1'b1;
    @(negedge clk);
    check("drst_in_ready", 64'(in_ready), 64'd0);
    check("drst_valid", 64'(res_valid), 64'd0);
    check("drst_len_err", 64'(len_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (res_valid === 1'b1) seen++;
      end
      check("drst_no_result", 64'(seen), 64'd0);
    end
    check("drst_ready_back", 64'(in_ready), 64'd1);
    send(18'd2, 18'd2, 1'b1);
    idle_in();
    wait_result("after_drst", 48'd4, 1);
    take("after_drst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Upstream operand sequencer for the Spartan6_DSP48A1 slice. It accepts a stream of (a, b) operand pairs over a valid/ready handshake, each vector terminated by in_last.
- It drives the slice's A, B and OPMODE inputs so the slice computes the dot product sum(a*b) in its P accumulator.
- After the pipeline drains, it captures P and CARRYOUT and presents them on a valid/ready result port.
- D, C, BCIN, PCIN and CARRYIN are tied to 0 at the slice by the parent. The pre-adder is unused.

Parameters:
- OP_W, 18, width of the a/b operands. Two's complement, passed straight through.
- P_W, 48, width of the captured P result.
- PIPE_LAT, 3, cycles from driving dsp_a/dsp_b to P reflecting that product. Default matches A1REG=B1REG=MREG=PREG=1 with A0REG=B0REG=0.
- MODE_DELAY, 1, extra cycles dsp_opmode is delayed relative to dsp_a/dsp_b so it meets the matching product at the post-adder. Legal range 0..3.
- CNT_W, 10, width of the beat counter. Maximum vector length is 2^CNT_W-1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous reset, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  sequencer accepts a beat this cycle.
- in_a  in  OP_W  multiplicand.
- in_b  in  OP_W  multiplier.
- in_last  in  1  final beat of the vector.
- dsp_a  out  18  to DSP A.
- dsp_b  out  18  to DSP B.
- dsp_opmode  out  8  to DSP OPMODE.
- dsp_p  in  P_W  from DSP P.
- dsp_carryout  in  1  from DSP CARRYOUT.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_data  out  P_W  captured dot product.
- res_carry  out  1  captured CARRYOUT.
- res_len  out  CNT_W  number of beats in the vector.
- len_err  out  1  sticky: beat count overflowed. Cleared only by RST.

Behaviour:
- Reset: state=IDLE. in_ready=0 while RST is high. dsp_a, dsp_b, res_data, res_carry, res_len, res_valid and len_err are all 0. dsp_opmode=OP_HOLD, and the whole delay line is filled with OP_HOLD.
- All outputs are registered. A beat is accepted when in_valid&in_ready at the rising edge.
- Opcodes: OP_MUL=8'h01 (X=M, Z=0), OP_ACC=8'h09 (X=M, Z=P), OP_HOLD=8'h08 (X=0, Z=P).
- Opmode alignment: the op chosen at acceptance enters a MODE_DELAY-deep delay line before reaching dsp_opmode. Operands are registered once onto dsp_a/dsp_b.
- IDLE:
  - in_ready=1.
  - On accept: drive a/b, issue OP_MUL, set count=1.
  - If in_last, go to DRAIN; otherwise go to ACCUM.
- ACCUM:
  - in_ready=1.
  - On accept: drive a/b, issue OP_ACC, increment count.
  - If in_last, go to DRAIN.
  - Cycle with no accept (bubble): dsp_a=dsp_b=0 and OP_HOLD is issued, so P is unchanged.
- DRAIN:
  - in_ready=0, dsp_a=dsp_b=0, OP_HOLD issued.
  - A down-counter is loaded with PIPE_LAT+MODE_DELAY on entry.
  - When it reaches 0: capture dsp_p into res_data, dsp_carryout into res_carry and count into res_len, then go to OUT.
- OUT:
  - res_valid=1, in_ready=0, OP_HOLD issued.
  - On res_valid&res_ready: res_valid drops on the next edge and state returns to IDLE.
  - res_data, res_carry and res_len are held until the next capture.
- Latency: if the last beat is accepted at edge t, res_valid rises at edge t+PIPE_LAT+MODE_DELAY+1.
- Beat counter overflow: incrementing past 2^CNT_W-1 saturates count and sets len_err. The accumulation itself continues.
- in_last on a cycle where in_valid=0 is ignored.
- Reset mid-operation (RST high during ACCUM, DRAIN or OUT): immediate return to IDLE, any pending result is discarded, and res_valid=0. The DSP's own P is not reset by this block; the next vector starts with OP_MUL, so stale P is discarded.
- Arithmetic: no width conversion. in_a/in_b are forwarded unmodified; signedness is the slice's.

Decomposition:
- Package dsp_seq_pkg holds:
  - OP_MUL, OP_ACC, OP_HOLD constants;
  - the state encoding (IDLE=2'd0, ACCUM=2'd1, DRAIN=2'd2, OUT=2'd3);
  - a function computing the drain count from PIPE_LAT and MODE_DELAY.
- One sub-module: dsp_opmode_delay, a parameterised 8-bit shift register.
  - Depth is MODE_DELAY; depth 0 is a wire-through.
  - It resets to OP_HOLD.

Test Plan:
- Single beat: a=15, b=2, last=1, sequencer feeding a real slice -> res_data=30, res_len=1, res_valid rises 5 edges after accept (default parameters).
- Three beats back-to-back: (3,4), (5,6), (7,8) with last on the third -> res_data=12+30+56=98, res_len=3, exactly one OP_MUL followed by two OP_ACC on dsp_opmode.
- Bubbles: beats (2,3), gap of 4 cycles, (4,5) last -> res_data=26, with OP_HOLD on dsp_opmode and dsp_a=dsp_b=0 during the gap.
- Result backpressure: res_ready=0 for 10 cycles after res_valid -> res_data stable and in_ready=0 throughout; the following vector (1,1) last -> res_data=1, proving stale P was discarded.
- Signed values: (-7,9), (10,10) -> res_data=100-63=37. A second vector (-5,5) last -> res_data=-25 sign-extended to 48 bits.
- Reset during DRAIN: assert RST 1 cycle after the last beat of (100,100) -> res_valid never rises, in_ready=1 after RST falls, next vector (2,2) -> res_data=4.
